// File: rtl/md_scheduler.sv
// Multiply/divide issue scheduler: launches the multdiv unit from D/X, tracks the pending result,
// raises data/structural hazard stalls and requests a regfile write-back slot for the result.
module md_scheduler (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_instr,
  input  logic [4:0]  fd_rs,
  input  logic [4:0]  fd_rt,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic        mw_we,
  output logic        ctrl_mult,
  output logic        ctrl_div,
  output logic        stall_front,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        md_wb_en,
  output logic [4:0]  md_wb_rd,
  output logic        md_wb_exc,
  output logic        md_busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StWb   = 2'd2;

  localparam logic [4:0] AluMul = 5'b00110;
  localparam logic [4:0] AluDiv = 5'b00111;
  localparam logic [4:0] ExcRd  = 5'd30;

  logic [1:0] state_q, state_d;
  logic [5:0] wd_q, wd_d;
  logic [4:0] md_rd_q, md_rd_d;
  logic       exc_q, exc_d;

  logic [4:0] dx_rd;
  logic       is_mul, is_div, is_md, busy, wb_needed;
  logic [4:0] hz_tgt;
  logic       hz_data, hz_struct;

  // Nonzero source matches the tracked destination or the exception register.
  function automatic logic src_hit(input logic [4:0] r, input logic [4:0] tgt);
    return (r != 5'd0) && ((r == tgt) || (r == ExcRd));
  endfunction

  assign dx_rd     = dx_instr[26:22];
  assign is_mul    = (dx_instr[31:27] == 5'd0) && (dx_instr[6:2] == AluMul);
  assign is_div    = (dx_instr[31:27] == 5'd0) && (dx_instr[6:2] == AluDiv);
  assign is_md     = is_mul | is_div;
  assign busy      = (state_q != StIdle);
  assign wb_needed = exc_q | (md_rd_q != 5'd0);

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    md_rd_d = md_rd_q;
    exc_d   = exc_q;
    case (state_q)
      StIdle: begin
        if (is_md) begin
          state_d = StBusy;
          md_rd_d = dx_rd;
          wd_d    = 6'd0;
          exc_d   = 1'b0;
        end
      end
      StBusy: begin
        wd_d = wd_q + 6'd1;
        if (md_ready) begin
          exc_d   = md_exception;
          state_d = StWb;
        end else if (wd_q == 6'd63) begin
          exc_d   = 1'b1;
          state_d = StWb;
        end
      end
      StWb: begin
        // A null write (rd 0, no exception) gets exactly one WB cycle.
        if (!wb_needed || !mw_we) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hz_tgt    = busy ? md_rd_q : dx_rd;
    hz_struct = busy & is_md;
    hz_data   = (busy | is_md) & (src_hit(fd_rs, hz_tgt) | src_hit(fd_rt, hz_tgt));

    ctrl_mult   = ~busy & is_mul;
    ctrl_div    = ~busy & is_div;
    stall_front = hz_struct | hz_data;
    stall_dx    = hz_struct;
    bubble_dx   = hz_data & ~hz_struct;
    bubble_xm   = is_md;
    md_wb_en    = (state_q == StWb) & wb_needed & ~mw_we;
    md_wb_rd    = exc_q ? ExcRd : md_rd_q;
    md_wb_exc   = exc_q;
    md_busy     = busy;

    if (reset) begin
      ctrl_mult   = 1'b0;
      ctrl_div    = 1'b0;
      stall_front = 1'b0;
      stall_dx    = 1'b0;
      bubble_dx   = 1'b0;
      bubble_xm   = 1'b0;
      md_wb_en    = 1'b0;
      md_wb_rd    = 5'd0;
      md_wb_exc   = 1'b0;
      md_busy     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      wd_q    <= 6'd0;
      md_rd_q <= 5'd0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      md_rd_q <= md_rd_d;
      exc_q   <= exc_d;
    end
  end

endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high.
REQ-003 SHALL have: dx_instr  in  32  instruction in D/X latch (opcode [31:27], rd [26:22], aluop [6:2]).
REQ-004 SHALL have: fd_rs, fd_rt  in  5 each  source registers decoded from F/D instruction (0 = unused).
REQ-005 SHALL have: md_ready, md_exception  in  1 each  result-valid and exception flags from the multdiv unit.
REQ-006 SHALL have: mw_we  in  1  pipeline M/W stage is writing the regfile this cycle.
REQ-007 SHALL have: ctrl_mult, ctrl_div  out  1 each  one-cycle start pulses to the multdiv unit.
REQ-008 SHALL have: stall_front  out  1  hold PC and F/D; stall_dx  out  1  hold D/X.
REQ-009 SHALL have: bubble_dx, bubble_xm  out  1 each  load nop into D/X or X/M.
REQ-010 SHALL have: md_wb_en  out  1, md_wb_rd  out  5, md_wb_exc  out  1  regfile write-port request for the multdiv result.
REQ-011 SHALL have: md_busy  out  1  state is not IDLE.

Function
REQ-012 SHALL decode dx_instr as multdiv when opcode = 00000 and aluop = 00110 (mul) or 00111 (div).
REQ-013 SHALL implement states IDLE, BUSY, WB; 6-bit watchdog counter wd; 5-bit register md_rd; 1-bit register exc.
REQ-014 IDLE with multdiv in D/X: SHALL pulse ctrl_mult or ctrl_div combinationally that cycle, assert bubble_xm (issuing instruction does not write back through pipeline), latch md_rd = rd, clear wd and exc, go BUSY next edge.
REQ-015 BUSY: wd SHALL increment each cycle; md_ready = 1 SHALL latch exc = md_exception and go WB next edge.
REQ-016 BUSY with wd = 63 and md_ready = 0: SHALL set exc = 1 and go WB (watchdog timeout); md_ready in same cycle as wd = 63 takes precedence.
REQ-017 WB: md_wb_en = ~mw_we (pipeline owns the port when mw_we = 1); leave to IDLE on the edge after md_wb_en = 1; remain in WB otherwise, no limit.
REQ-018 md_wb_rd SHALL be 30 when exc = 1, else md_rd; md_wb_exc = exc.
REQ-019 md_rd = 0 with exc = 0: SHALL still sequence BUSY/WB but md_wb_en SHALL stay 0 (one WB cycle, then IDLE).
REQ-020 Data hazard: when BUSY or WB, if nonzero fd_rs or fd_rt equals md_rd, or equals 30 (possible exception target), SHALL assert stall_front and bubble_dx; same check against dx rd in the issue cycle of REQ-014.
REQ-021 Structural hazard: multdiv in D/X while BUSY or WB SHALL assert stall_front, stall_dx, bubble_xm; no ctrl pulse; issues from IDLE after completion.
REQ-022 Structural hazard takes precedence over data hazard: bubble_dx = 0 whenever stall_dx = 1.
REQ-023 md_ready or md_exception in IDLE or WB SHALL be ignored.
REQ-024 Issue latency 0 cycles (pulse in decode cycle); writeback earliest 1 cycle after md_ready.

Reset
REQ-025 reset = 1 SHALL force state IDLE, wd = 0, md_rd = 0, exc = 0 on next edge, and all outputs 0 while asserted, regardless of other inputs.
REQ-026 Reset mid-operation SHALL abandon the pending result; a later md_ready SHALL not produce md_wb_en.

Verification
REQ-027 mul rd=5 in D/X, md_ready at cycle +4, mw_we=0 -> ctrl_mult one cycle, md_busy 1..5, md_wb_en=1 with md_wb_rd=5 one cycle after ready, then IDLE.
REQ-028 div rd=7 issued, F/D has fd_rs=7 -> stall_front and bubble_dx every cycle until cycle after md_wb_en; fd_rs=8 -> no stall (unless 8 unrelated, rd 30 check still applies for fd_rs=30).
REQ-029 Second mul in D/X while BUSY -> stall_front, stall_dx, bubble_xm held, no ctrl_mult; ctrl_mult pulses the cycle state returns IDLE.
REQ-030 md_ready with md_exception=1, mw_we=1 for 3 cycles -> stays WB 3 cycles, then md_wb_en=1, md_wb_rd=30, md_wb_exc=1.
REQ-031 No md_ready after issue -> WB entered after wd reaches 63, md_wb_rd=30, md_wb_exc=1.
REQ-032 reset pulsed while BUSY, then md_ready=1 -> all outputs 0, md_wb_en never asserted, md_busy=0.
